// File: rtl/aes_128_key_expand.sv
// aes_128_key_expand
// Iterative AES-128 key schedule. A single start pulse captures a 128-bit
// cipher key into round-key slot 0. One further round key is then derived on
// each clock until slot 10 is written.
//
// Ports:
//   clk        - system clock, rising-edge active
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle request to expand key_in (only honoured when idle)
//   key_in     - 128-bit cipher key, key_in[127:96] is word w0
//   busy       - high while the schedule is being computed
//   done       - one-cycle pulse after round key 10 has been written
//   keys_valid - level, the store holds a complete schedule
//   rk_addr    - round-key index for the read port (0..10)
//   rk_data    - combinational read of round key rk_addr, zero above 10

module aes_128_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [0:0]   state;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] rk [0:10];

    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp;
    logic [31:0]  nw0;
    logic [31:0]  nw1;
    logic [31:0]  nw2;
    logic [31:0]  nw3;
    logic [7:0]   rcon_next;

    // Entry b lives at bit offset (255 - b) * 8, and 255 - b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    assign busy = (state == EXPAND);

    // The key for the round being built is always the entry just below the
    // round counter, so select it out of the store rather than keeping a
    // separate working copy.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (round == 4'(i + 1)) begin
                prev_key = rk[i];
            end
        end
    end

    // One round of the schedule: rotate and substitute the last word, fold in
    // rcon, then chain the XORs across the four words.
    always_comb begin
        rot_word  = {prev_key[23:0], prev_key[31:24]};
        sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        temp      = sub_word ^ {rcon, 24'h0};
        nw0       = prev_key[127:96] ^ temp;
        nw1       = prev_key[95:64]  ^ nw0;
        nw2       = prev_key[63:32]  ^ nw1;
        nw3       = prev_key[31:0]   ^ nw2;
        next_key  = {nw0, nw1, nw2, nw3};
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // Read port: addresses past the last round key return zero.
    always_comb begin
        rk_data = '0;
        for (int i = 0; i < 11; i++) begin
            if (rk_addr == 4'(i)) begin
                rk_data = rk[i];
            end
        end
    end

    // Control and store. In IDLE a start captures the key and clears
    // keys_valid. A start arriving on the done cycle is therefore accepted
    // too. In EXPAND only the slot matching the counter is written, and the
    // start input is not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            round      <= 4'd0;
            rcon       <= 8'h01;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                rk[i] <= '0;
            end
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                rk[0]      <= key_in;
                round      <= 4'd1;
                rcon       <= 8'h01;
                keys_valid <= 1'b0;
                state      <= EXPAND;
            end
        end else begin
            for (int i = 1; i < 11; i++) begin
                if (round == 4'(i)) begin
                    rk[i] <= next_key;
                end
            end
            rcon <= rcon_next;
            if (round == 4'd10) begin
                state      <= IDLE;
                round      <= 4'd0;
                done       <= 1'b1;
                keys_valid <= 1'b1;
            end else begin
                round <= round + 4'd1;
            end
        end
    end

endmodule

// File: doc/aes_128_key_expand.md
Name: aes_128_key_expand

Overview:
Iterative AES-128 key schedule (FIPS-197 §5.2) that sits directly upstream of aes_128. It accepts a 128-bit cipher key and computes one round key per clock into an internal 11-entry round-key store. It exposes the stored round keys through a combinational read port. aes_128 and the cipher-side sequencers index this port by round number instead of re-deriving keys.

Parameters:
None. The block is AES-128 only: 10 rounds, 11 round keys, fixed.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to expand key_in; sampled only in IDLE
key_in  input  128  cipher key; key_in[127:96] = w0, byte order as FIPS-197 (MSB byte first)
busy  output  1  high while an expansion is in progress
done  output  1  one-cycle pulse when round key 10 has been written
keys_valid  output  1  level; store holds a complete, consistent schedule
rk_addr  input  4  round-key index, 0..10
rk_data  output  128  combinational read of round key rk_addr; 128'h0 for rk_addr > 10

Behaviour:
- Reset (rst_n low, async): state=IDLE, round counter=0, rcon=8'h01, all 11 store entries=0. busy=0, done=0, keys_valid=0, so rk_data=0 for every address.
- States:
  - IDLE -> EXPAND on start.
  - EXPAND -> IDLE after round 10 is written.
  - No other states.
- Edge naming: the rising edge at which start is sampled in IDLE is E0.
  - At E0: key_in is captured into rk[0], counter=1, rcon=8'h01, busy=1, keys_valid=0.
- Edge Ek, k=1..10: rk[k] = f(rk[k-1], rcon).
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - After each round, rcon = xtime(rcon) (shift left by 1; if bit7 was set, XOR 8'h1b). The sequence is 01,02,04,08,10,20,40,80,1b,36.
- At E10:
  - busy drops to 0.
  - done=1 for exactly the cycle following E10; it returns to 0 at E11.
  - keys_valid=1 and stays high until the next accepted start or reset.
- Latency: start at E0 -> done visible after E10 (10 cycles). One expansion per 11 cycles at most.
- S-box: four byte lookups per cycle through an internal combinational 256-entry FIPS-197 S-box. No registered lookups.
- Store write ordering: only entry k is written at Ek. Earlier entries keep their values.
- start while busy: ignored; key_in is not re-sampled and the expansion in progress completes unchanged.
- start in the same cycle as done: accepted, because the state is IDLE. keys_valid clears at that edge and a new expansion begins.
- key_in changing after E0: no effect.
- rk_addr is combinational.
  - Reads during EXPAND return whatever is currently stored: fresh entries for k < counter, previous-schedule or zero entries for others.
  - Consumers must gate reads on keys_valid.
- Reset mid-expansion: immediate return to the reset values above. No partial keys_valid, no done pulse.

Test Plan:
- FIPS-197 A.1 key:
  - Stimulus: reset; start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Response: done 10 cycles after the start edge.
  - rk[1]=a0fafe1788542cb123a339392a6c7605.
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk[0]=key_in; keys_valid=1.
- All-zero key:
  - Response: rk[1]=62636363626363636263636362636363.
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
  - Exercises the rcon wrap 80->1b->36.
- start pulsed again at cycles 3 and 7 of an A.1 expansion with key_in=all-ones:
  - Response: ignored; the final schedule equals the A.1 result; done pulses once.
- rst_n asserted at cycle 5 of an expansion:
  - Response: busy, done and keys_valid go 0 immediately; rk_data reads 0 for addr 0..10.
  - A following start with the A.1 key completes correctly.
- Back-to-back expansions:
  - Stimulus: A.1 key, then start on the done cycle with the zero key.
  - Response: keys_valid drops at that edge; the second done arrives 10 cycles later; rk[10]=b4ef5bcb....
- Read port bounds:
  - Response: rk_addr=11..15 returns 0; rk_addr=0 returns the captured key.
  - rk_data tracks rk_addr changes in the same cycle, with no register delay.
